// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   NIB_W  : width of the arithmetic slice (one nibble)
//   S_*    : controller state encoding; 2'd3 is unused and recovers to IDLE
package nibble_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/nibble_add_slice.sv
// 4-bit ripple adder slice built from full-adder cells.
//   i_a, i_b : nibble operands
//   i_cin    : carry in (from the controller's carry register)
//   o_s      : nibble sum
//   o_cout   : carry out of bit 3
//   o_c3     : carry into bit 3, used for two's-complement overflow
module nibble_add_slice
  import nibble_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_cin,
  output logic [NIB_W-1:0] o_s,
  output logic             o_cout,
  output logic             o_c3
);

  logic [NIB_W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    nibble_full_adder u_fa (
      .i_a    (i_a[i]),
      .i_b    (i_b[i]),
      .i_cin  (w_c[i]),
      .o_s    (o_s[i]),
      .o_cout (w_c[i+1])
    );
  end

  assign o_cout = w_c[NIB_W];
  assign o_c3   = w_c[NIB_W-1];

endmodule

// File: rtl/nibble_full_adder.sv
// Single-bit full adder cell, the building block of the nibble slice.
//   i_a, i_b, i_cin : addend bits and carry in
//   o_s, o_cout     : sum bit and carry out
module nibble_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract performed one nibble per cycle through a single
// 4-bit slice, with the inter-nibble carry held in a register.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake (in_a, in_b, in_sub)
//   out_valid/out_ready  : result handshake (out_sum, out_cout, out_ovf)
//   o_dbg_state          : current controller state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE, out_valid is 1 only in DONE, so the two
// are never high together and a result is never taken in the same cycle as a
// new operand. Outputs are held stable for as long as out_valid is 1.
module nibble_serial_adder_ctrl
  import nibble_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [1:0]       o_dbg_state
);

  localparam int N     = WIDTH / NIB_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(N - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [NIB_W-1:0] w_s;
  logic             w_cout;
  logic             w_c3;

  // The slice always sees the lowest nibble of the shifting operands.
  nibble_add_slice u_slice (
    .i_a    (r_op_a[NIB_W-1:0]),
    .i_b    (r_op_b[NIB_W-1:0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout),
    .o_c3   (w_c3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op_a  <= in_a;
            // Subtraction is A + ~B + 1: invert B here, the +1 is the carry-in.
            r_op_b  <= in_sub ? ~in_b : in_b;
            r_carry <= in_sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_op_a  <= r_op_a >> NIB_W;
          r_op_b  <= r_op_b >> NIB_W;
          // Nibbles enter at the top so after N steps nibble 0 sits at the bottom.
          r_sum   <= {w_s, r_sum[WIDTH-1:NIB_W]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_NIB) begin
            r_cout  <= w_cout;
            r_ovf   <= w_c3 ^ w_cout;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_sum     = r_sum;
  assign out_cout    = r_cout;
  assign out_ovf     = r_ovf;
  assign o_dbg_state = r_state;

endmodule
